// File: rtl/avmm_ocram_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// avmm_ocram_pkg: shared types and elaboration helpers for the pipelined OCRAM
// Revision: 1.0 - initial release
// ============================================================================
package avmm_ocram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int RL_DIRECT     = 1;
    localparam int RL_REGISTERED = 2;

    function automatic bit data_w_ok(input int unsigned w);
        return (w != 0) && ((w % 8) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_ocram_pipelined_if.sv
`default_nettype none
// ============================================================================
// avmm_ocram_pipelined_if: Avalon-MM slave bus bundle for the OCRAM
// Revision: 1.0 - initial release
// ============================================================================
interface avmm_ocram_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/avmm_ocram_pipelined_sp_core.sv
`default_nettype none
// ============================================================================
// ocram_sp_core: single-port byte-lane RAM with one-cycle read-old-data output
// Revision: 1.0 - initial release
// ============================================================================
module ocram_sp_core #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 16384,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int NB = DATA_W / 8;

    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Output only moves on a real read so the bus sees held data otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/avmm_ocram_pipelined.sv
`default_nettype none
// ============================================================================
// avmm_ocram_pipelined: Avalon-MM OCRAM slave with clear sequencer, freeze and
// selectable read latency. Revision: 1.0 - initial release
// ============================================================================
module avmm_ocram_pipelined
    import avmm_ocram_pkg::*;
#(
    parameter int    DATA_W         = 32,
    parameter int    DEPTH          = 16384,
    parameter int    ADDR_W         = $clog2(DEPTH),
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    input  logic reset_req,
    input  logic freeze,
    avmm_ocram_pipelined_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam string             CORE_INIT   = (CLEAR_ON_RESET != 0) ? "" : INIT_FILE;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                en;
    logic                clearing;
    logic                waitreq;
    logic                wr_acc;
    logic                rd_acc;
    logic                core_we;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W/8-1:0] core_be;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W-1:0]   core_rdata;

    if (!data_w_ok(DATA_W) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_geometry
        $error("avmm_ocram_pipelined: DATA_W must be a multiple of 8 and DEPTH a power of 2");
    end

    assign en       = clken & ~reset_req;
    assign clearing = (state_q == ST_CLEAR);
    assign waitreq  = clearing | ~en;
    assign bus.waitrequest = waitreq;

    // A simultaneous read+write is a write only, so it never enters the pipe.
    assign wr_acc = bus.chipselect & bus.write & ~waitreq;
    assign rd_acc = bus.chipselect & bus.read & ~bus.write & ~waitreq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR && en) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    assign core_we    = clearing | (wr_acc & ~freeze);
    assign core_addr  = clearing ? cnt_q : bus.address;
    assign core_be    = clearing ? '1 : bus.byteenable;
    assign core_wdata = clearing ? '0 : bus.writedata;

    ocram_sp_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (CORE_INIT)
    ) u_core (
        .clk     (clk),
        .rst_n   (reset_n),
        .en_i    (en),
        .we_i    (core_we),
        .re_i    (rd_acc),
        .addr_i  (core_addr),
        .be_i    (core_be),
        .wdata_i (core_wdata),
        .rdata_o (core_rdata)
    );

    if (READ_LATENCY == RL_DIRECT) begin : g_lat1
        logic vld_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= 1'b0;
            end else if (en) begin
                vld_q <= rd_acc;
            end
        end

        assign bus.readdata      = core_rdata;
        assign bus.readdatavalid = vld_q;
    end else if (READ_LATENCY == RL_REGISTERED) begin : g_lat2
        logic [1:0]        vld_q;
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q   <= 2'b00;
                rdata_q <= '0;
            end else if (en) begin
                vld_q <= {vld_q[0], rd_acc};
                if (vld_q[0]) begin
                    rdata_q <= core_rdata;
                end
            end
        end

        assign bus.readdata      = rdata_q;
        assign bus.readdatavalid = vld_q[1];
    end else begin : g_bad_latency
        $error("avmm_ocram_pipelined: READ_LATENCY must be 1 or 2");
    end

endmodule
`default_nettype wire

// File: tb/tb_avmm_ocram_pipelined.sv
`default_nettype none
// ============================================================================
// tb_avmm_ocram_pipelined: checks latency-1 and latency-2 instances side by
// side against a queue-based reference model. Revision: 1.0
// ============================================================================
module tb_avmm_ocram_pipelined;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          reset_n;
    logic          clken;
    logic          reset_req;
    logic          freeze;
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;

    avmm_ocram_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    avmm_ocram_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    assign bus1.address = addr;  assign bus2.address = addr;
    assign bus1.byteenable = be; assign bus2.byteenable = be;
    assign bus1.chipselect = cs; assign bus2.chipselect = cs;
    assign bus1.read = rd;       assign bus2.read = rd;
    assign bus1.write = wr;      assign bus2.write = wr;
    assign bus1.writedata = wdata; assign bus2.writedata = wdata;

    avmm_ocram_pipelined #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .freeze(freeze), .bus(bus1)
    );

    avmm_ocram_pipelined #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .freeze(freeze), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    logic [DW-1:0] mem_m [DEPTH];
    ret_t          q1[$];
    ret_t          q2[$];
    int            clear_left;
    int            ecnt;
    logic          ev1, ev2;
    logic [DW-1:0] ed1, ed2;
    int            n_cmp;
    int            n_bad;
    int            n;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        q1.delete();
        q2.delete();
        clear_left = DEPTH;
        ecnt = 0;
        ev1 = 1'b0; ev2 = 1'b0;
        ed1 = '0;   ed2 = '0;
    endtask

    // One clock: predict from the inputs in force, then check after the edge.
    task automatic tick();
        logic          en_m;
        logic          acc;
        logic [DW-1:0] rv;
        #1;
        en_m = clken & ~reset_req;
        chk("waitrequest_rl1", DW'(bus1.waitrequest), DW'((clear_left > 0) || !en_m));
        chk("waitrequest_rl2", DW'(bus2.waitrequest), DW'((clear_left > 0) || !en_m));
        if (en_m) begin
            acc = (clear_left == 0) && cs && (rd || wr);
            if (clear_left > 0) clear_left--;
            ecnt++;
            rv = mem_m[addr];
            if (acc && rd && !wr) begin
                q1.push_back('{data: rv, due: ecnt});
                q2.push_back('{data: rv, due: ecnt + 1});
            end
            if (acc && wr && !freeze) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[addr][8*b +: 8] = wdata[8*b +: 8];
            end
            ev1 = 1'b0;
            if (q1.size() > 0 && q1[0].due == ecnt) begin
                ev1 = 1'b1; ed1 = q1[0].data; void'(q1.pop_front());
            end
            ev2 = 1'b0;
            if (q2.size() > 0 && q2[0].due == ecnt) begin
                ev2 = 1'b1; ed2 = q2[0].data; void'(q2.pop_front());
            end
        end
        @(posedge clk);
        #1;
        chk("rdvalid_rl1", DW'(bus1.readdatavalid), DW'(ev1));
        chk("rdvalid_rl2", DW'(bus2.readdatavalid), DW'(ev2));
        chk("rdata_rl1", bus1.readdata, ed1);
        chk("rdata_rl2", bus2.readdata, ed2);
    endtask

    task automatic req(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] b);
        cs = r | w; rd = r; wr = w; addr = a; wdata = d; be = b;
        tick();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic do_reset();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", DW'(bus1.waitrequest), DW'(1));
        chk("rst_rdvalid_rl1", DW'(bus1.readdatavalid), DW'(0));
        chk("rst_rdvalid_rl2", DW'(bus2.readdatavalid), DW'(0));
        chk("rst_rdata_rl1", bus1.readdata, '0);
        chk("rst_rdata_rl2", bus2.readdata, '0);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic wait_clear();
        n = 0;
        while (bus1.waitrequest && n < 200) begin
            tick();
            n++;
        end
        chk("clear_length", DW'(n), DW'(DEPTH));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        wait_clear();

        // Cleared array reads back zero.
        req(1, 0, 0, '0, '0);
        req(1, 0, 31, '0, '0);
        req(1, 0, 63, '0, '0);
        req(0, 0, 0, '0, '0);
        req(0, 0, 0, '0, '0);

        // Byte-lane merge seen at both latencies.
        req(0, 1, 5, 32'hDEADBEEF, 4'b1111);
        req(0, 1, 5, 32'h000000AA, 4'b0001);
        req(0, 1, 5, 32'h12345678, 4'b0000);
        req(1, 0, 5, '0, '0);
        chk("merge_rl1", bus1.readdata, 32'hDEADBEAA);
        chk("merge_rl2_pending", DW'(bus2.readdatavalid), DW'(0));
        req(0, 0, 0, '0, '0);
        chk("merge_rl2", bus2.readdata, 32'hDEADBEAA);

        // Burst with a two-cycle clken stall in the middle.
        for (int i = 1; i <= 4; i++) req(0, 1, AW'(i), DW'(i * 32'h11), 4'b1111);
        req(1, 0, 1, '0, '0);
        req(1, 0, 2, '0, '0);
        cs = 1'b1; rd = 1'b1; addr = 3; clken = 1'b0;
        tick();
        tick();
        clken = 1'b1;
        req(1, 0, 3, '0, '0);
        req(1, 0, 4, '0, '0);
        req(0, 0, 0, '0, '0);
        req(0, 0, 0, '0, '0);

        // Read/write ordering on one address, and read+write collapsing to a write.
        req(0, 1, 7, 32'h1, 4'b1111);
        req(1, 0, 7, '0, '0);
        req(0, 1, 7, 32'h2, 4'b1111);
        req(1, 0, 7, '0, '0);
        req(1, 1, 7, 32'h3, 4'b1111);
        chk("rw_both_novalid", DW'(bus1.readdatavalid), DW'(0));
        req(1, 0, 7, '0, '0);
        chk("rw_both_newdata", bus1.readdata, 32'h3);
        req(0, 0, 0, '0, '0);

        // Frozen write is accepted but leaves the array untouched.
        freeze = 1'b1;
        cs = 1'b1; wr = 1'b1; addr = 9; wdata = 32'h55; be = 4'b1111;
        #1;
        chk("freeze_accept", DW'(bus1.waitrequest), DW'(0));
        tick();
        freeze = 1'b0;
        req(1, 0, 9, '0, '0);
        chk("freeze_discard", bus1.readdata, 32'h0);
        req(0, 0, 0, '0, '0);

        // Randomized traffic with stalls, reset_req and freeze.
        for (int i = 0; i < 400; i++) begin
            clken     = ($urandom_range(0, 7) != 0);
            reset_req = ($urandom_range(0, 15) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            cs        = ($urandom_range(0, 3) != 0);
            rd        = $urandom_range(0, 1) == 1;
            wr        = $urandom_range(0, 2) == 0;
            addr      = AW'($urandom_range(0, 15));
            be        = 4'($urandom);
            wdata     = $urandom;
            tick();
        end
        clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
        req(0, 0, 0, '0, '0);
        req(0, 0, 0, '0, '0);

        // Reset in the middle of the clear restarts it from address 0.
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        do_reset();
        wait_clear();
        for (int i = 0; i < 16; i++) req(1, 0, AW'(i * 4 + 3), '0, '0);
        req(0, 0, 0, '0, '0);
        req(0, 0, 0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
